serial_sub_ctrl: RTL and testbench

SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

---
 rtl/serial_sub_pkg.sv | 12 +
 rtl/serial_sub_cell.sv | 13 +
 rtl/serial_sub_ctrl.sv | 125 ++++++++++++
 tb/tb_serial_sub_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package serial_sub_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

endpackage

// File: rtl/serial_sub_cell.sv
// Purely combinational 1-bit full subtractor: d = a - b - bin, bout = borrow out.
module serial_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor controller: captures a/b, subtracts LSB first through one
// full-subtractor cell, one bit per clock, and registers diff/borrow/zero on completion.
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] diff_sh_q, diff_sh_d;
    logic             brw_q, brw_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             zero_q, zero_d;

    logic cell_d;
    logic cell_bout;

    serial_sub_cell u_cell (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (brw_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // Next-state logic for the FSM, shift datapath and result registers.
    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        diff_sh_d = diff_sh_q;
        brw_d     = brw_q;
        cnt_d     = cnt_q;
        diff_d    = diff_q;
        borrow_d  = borrow_q;
        zero_d    = zero_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    brw_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                a_sh_d    = a_sh_q >> 1;
                b_sh_d    = b_sh_q >> 1;
                diff_sh_d = {cell_d, diff_sh_q[WIDTH-1:1]};
                brw_d     = cell_bout;
                cnt_d     = cnt_q + CntW'(1);
                if (cnt_q == CntLast) begin
                    // Last bit: publish the result; cnt restarts so it never exceeds WIDTH-1.
                    state_d  = StDone;
                    cnt_d    = '0;
                    diff_d   = diff_sh_d;
                    borrow_d = cell_bout;
                    zero_d   = (diff_sh_d == '0);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            diff_sh_q <= '0;
            brw_q     <= 1'b0;
            cnt_q     <= '0;
            diff_q    <= '0;
            borrow_q  <= 1'b0;
            zero_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            diff_sh_q <= diff_sh_d;
            brw_q     <= brw_d;
            cnt_q     <= cnt_d;
            diff_q    <= diff_d;
            borrow_q  <= borrow_d;
            zero_q    <= zero_d;
        end
    end

    // Status outputs decode directly from the registered state.
    always_comb begin
        busy = (state_q == StShift) || (state_q == StDone);
        done = (state_q == StDone);
    end

    assign diff   = diff_q;
    assign borrow = borrow_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl: directed cases plus randomized operands
// compared against plain arithmetic (a - b mod 2^W, a < b).
module tb_serial_sub_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
    logic         zero;

    int checks = 0;
    int errors = 0;

    // Last published result, used to check that outputs hold during an operation.
    logic [W-1:0] prev_diff;
    logic         prev_borrow;
    logic         prev_zero;

    serial_sub_ctrl #(
        .WIDTH (W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow),
        .zero   (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One subtraction from IDLE; optionally disturbs start/a/b while shifting.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit disturb);
        int           n;
        logic [W-1:0] ed;
        logic         eb;
        logic         ez;
        ed = av - bv;
        eb = (av < bv);
        ez = (ed == '0);

        a = av;
        b = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_accept", busy, 1);

        n = 0;
        while (done !== 1'b1 && n < W + 4) begin
            if (disturb && n == 1) begin
                start = 1'b1;
                a = ~av;
                b = bv + W'(77);
            end
            if (disturb && n == 4) start = 1'b0;
            if (n == W / 2) begin
                chk("hold_diff", diff, prev_diff);
                chk("hold_borrow", borrow, prev_borrow);
                chk("hold_zero", zero, prev_zero);
            end
            tick();
            n++;
        end
        start = 1'b0;

        chk("latency", n, W);
        chk("diff", diff, ed);
        chk("borrow", borrow, eb);
        chk("zero", zero, ez);
        chk("busy_in_done", busy, 1);
        prev_diff   = ed;
        prev_borrow = eb;
        prev_zero   = ez;

        tick();
        chk("done_one_cycle", done, 0);
        chk("idle_not_busy", busy, 0);

        if (disturb) begin
            for (int i = 0; i < W + 2; i++) begin
                tick();
                chk("no_restart_done", done, 0);
            end
        end
    endtask

    initial begin
        logic [W-1:0] pa [3];
        logic [W-1:0] pb [3];
        logic [W-1:0] ed;
        logic [W-1:0] av;
        logic [W-1:0] bv;
        int           idx;
        int           t;
        int           last_t;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();

        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_diff", diff, 0);
        chk("rst_borrow", borrow, 0);
        chk("rst_zero", zero, 1);
        prev_diff   = '0;
        prev_borrow = 1'b0;
        prev_zero   = 1'b1;

        rst_n = 1'b1;
        tick();

        do_op(8'h5A, 8'h3C, 1'b0);
        do_op(8'hFF, 8'hFF, 1'b0);
        do_op(8'hA7, 8'h19, 1'b1);
        do_op(8'h00, 8'h01, 1'b0);

        // Abort mid-operation with cnt at 3.
        a = 8'h12;
        b = 8'h34;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_diff", diff, 0);
        chk("abort_borrow", borrow, 0);
        chk("abort_zero", zero, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_no_done", done, 0);
        end
        rst_n = 1'b1;
        prev_diff   = '0;
        prev_borrow = 1'b0;
        prev_zero   = 1'b1;
        tick();
        do_op(8'hC3, 8'h5A, 1'b0);

        // Back-to-back with start held high.
        pa[0] = 8'h10; pb[0] = 8'h20;
        pa[1] = 8'h80; pb[1] = 8'h7F;
        pa[2] = 8'h33; pb[2] = 8'h33;
        idx = 0;
        t = 0;
        last_t = 0;
        a = pa[0];
        b = pb[0];
        start = 1'b1;
        while (idx < 3 && t < 60) begin
            tick();
            t++;
            if (done === 1'b1) begin
                ed = pa[idx] - pb[idx];
                chk("b2b_diff", diff, ed);
                chk("b2b_borrow", borrow, (pa[idx] < pb[idx]));
                chk("b2b_zero", zero, (ed == '0));
                if (idx > 0) chk("b2b_spacing", t - last_t, W + 2);
                last_t = t;
                prev_diff   = ed;
                prev_borrow = (pa[idx] < pb[idx]);
                prev_zero   = (ed == '0);
                idx++;
                if (idx < 3) begin
                    a = pa[idx];
                    b = pb[idx];
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        chk("b2b_count", idx, 3);
        tick();
        tick();

        // Randomized operands against plain arithmetic.
        for (int i = 0; i < 1000; i++) begin
            av = W'($urandom_range(0, 255));
            bv = W'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) bv = av;
            do_op(av, bv, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
